mem_lsu: RTL and testbench



---
 rtl/mem_lsu.sv | 188 ++++++++++++++++++
 tb/tb_mem_lsu.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit.
// Accepts one load or store from the pipeline, runs it over a simple
// request/ready + rvalid bus, and stalls the pipeline until it completes.
// Misaligned or illegal accesses raise exc_M immediately, without touching
// the bus. A bus that never responds is aborted after TIMEOUT_CYCLES.
module mem_lsu #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead_M,
  input  logic        memWrite_M,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] ALUResult_M,
  input  logic [31:0] writeData_M,
  output logic [31:0] r_Data_M,
  output logic        stall_M,
  output logic        exc_M,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [2:0]    funct3_q;
  logic [31:0]   r_data_q;
  logic          timeout_q;

  logic          access;
  logic          attempt;
  logic          kind_ok;
  logic          aligned;
  logic          legal;
  logic [3:0]    store_be;
  logic [31:0]   store_wdata;
  logic [31:0]   load_data;
  logic [31:0]   rdata_shifted;
  logic [7:0]    load_byte;
  logic [15:0]   load_half;
  logic          wait_expired;

  // Decode the incoming request: exactly one of read/write, a size legal
  // for that direction, and natural alignment for halfwords and words.
  always_comb begin
    access  = memRead_M ^ memWrite_M;
    attempt = memRead_M | memWrite_M;
    kind_ok = 1'b0;
    if (memRead_M) begin
      case (funct3_M)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: kind_ok = 1'b1;
        default:                                kind_ok = 1'b0;
      endcase
    end else begin
      case (funct3_M)
        3'b000, 3'b001, 3'b010: kind_ok = 1'b1;
        default:                kind_ok = 1'b0;
      endcase
    end
    case (funct3_M[1:0])
      2'b01:   aligned = ~ALUResult_M[0];
      2'b10:   aligned = (ALUResult_M[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    legal = access & kind_ok & aligned;
  end

  // Store lane encoding: replicate the data across all lanes and let the
  // byte enables pick the lane; loads carry no enables and no data.
  always_comb begin
    store_be    = 4'b0000;
    store_wdata = 32'h0;
    if (memWrite_M) begin
      case (funct3_M[1:0])
        2'b00: begin
          store_be    = 4'b0001 << ALUResult_M[1:0];
          store_wdata = {4{writeData_M[7:0]}};
        end
        2'b01: begin
          store_be    = ALUResult_M[1] ? 4'b1100 : 4'b0011;
          store_wdata = {2{writeData_M[15:0]}};
        end
        default: begin
          store_be    = 4'b1111;
          store_wdata = writeData_M;
        end
      endcase
    end
  end

  // Load extraction from the returned word using the latched lane and size.
  always_comb begin
    rdata_shifted = bus_rdata >> {addr_q[1:0], 3'b000};
    load_byte     = rdata_shifted[7:0];
    load_half     = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b100:  load_data = {24'h0, load_byte};
      3'b101:  load_data = {16'h0, load_half};
      default: load_data = bus_rdata;
    endcase
  end

  assign wait_expired = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Access sequencer: latch the request, hold it on the bus until accepted,
  // collect read data, then spend one DONE cycle presenting the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      we_q      <= 1'b0;
      be_q      <= 4'b0000;
      funct3_q  <= 3'b000;
      r_data_q  <= 32'h0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (legal) begin
            addr_q    <= ALUResult_M;
            wdata_q   <= store_wdata;
            we_q      <= memWrite_M;
            be_q      <= store_be;
            funct3_q  <= funct3_M;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
            r_data_q  <= 32'h0;
            state     <= REQ;
          end
        end
        REQ: begin
          wait_cnt <= wait_cnt + CW'(1);
          if (bus_ready) begin
            r_data_q <= 32'h0;
            state    <= we_q ? DONE : WAIT_R;
          end else if (wait_expired) begin
            r_data_q  <= 32'h0;
            timeout_q <= 1'b1;
            state     <= DONE;
          end
        end
        WAIT_R: begin
          wait_cnt <= wait_cnt + CW'(1);
          if (bus_rvalid) begin
            r_data_q <= load_data;
            state    <= DONE;
          end else if (wait_expired) begin
            r_data_q  <= 32'h0;
            timeout_q <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          timeout_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus_req   = (state == REQ);
  assign bus_we    = we_q;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

  assign stall_M  = ~reset & ((state == IDLE && legal) || state == REQ || state == WAIT_R);
  assign exc_M    = ~reset & ((state == IDLE && attempt && !legal) || (state == DONE && timeout_q));
  assign r_Data_M = (state == DONE) ? r_data_q : 32'h0;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu.
// Inputs change just after each falling edge and outputs are sampled 1ns
// later, well away from the rising edge that advances the DUT.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead_M;
  logic        memWrite_M;
  logic [2:0]  funct3_M;
  logic [31:0] ALUResult_M;
  logic [31:0] writeData_M;
  logic [31:0] r_Data_M;
  logic        stall_M;
  logic        exc_M;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int checkCount = 0;
  int errorCount = 0;

  mem_lsu #(.TIMEOUT_CYCLES(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .memRead_M  (memRead_M),
    .memWrite_M (memWrite_M),
    .funct3_M   (funct3_M),
    .ALUResult_M(ALUResult_M),
    .writeData_M(writeData_M),
    .r_Data_M   (r_Data_M),
    .stall_M    (stall_M),
    .exc_M      (exc_M),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_ready  (bus_ready),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  // Free-running 10ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One cycle: wait for the falling edge, drive every input, settle 1ns.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic rdy, input logic rv, input logic [31:0] rdata);
    @(negedge clk);
    memRead_M   = rd;
    memWrite_M  = wr;
    funct3_M    = f3;
    ALUResult_M = addr;
    writeData_M = wd;
    bus_ready   = rdy;
    bus_rvalid  = rv;
    bus_rdata   = rdata;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Load with immediate ready and rvalid one cycle later.
  task automatic runLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] expAddr, input logic [31:0] rdata, input logic [31:0] expData);
    applyStimulus(1'b1, 1'b0, f3, addr, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput({tag, "_launch_stall"}, 32'(stall_M), 32'd1);
    checkOutput({tag, "_launch_exc"}, 32'(exc_M), 32'd0);
    applyStimulus(1'b1, 1'b0, f3, addr, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    checkOutput({tag, "_req"}, 32'(bus_req), 32'd1);
    checkOutput({tag, "_addr"}, bus_addr, expAddr);
    checkOutput({tag, "_be"}, 32'(bus_be), 32'h0);
    checkOutput({tag, "_we"}, 32'(bus_we), 32'd0);
    checkOutput({tag, "_req_stall"}, 32'(stall_M), 32'd1);
    applyStimulus(1'b1, 1'b0, f3, addr, 32'h0, 1'b0, 1'b1, rdata);
    checkOutput({tag, "_wait_req"}, 32'(bus_req), 32'd0);
    checkOutput({tag, "_wait_stall"}, 32'(stall_M), 32'd1);
    applyStimulus(1'b1, 1'b0, f3, addr, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput({tag, "_done_data"}, r_Data_M, expData);
    checkOutput({tag, "_done_stall"}, 32'(stall_M), 32'd0);
    checkOutput({tag, "_done_exc"}, 32'(exc_M), 32'd0);
    idleCycle();
    checkOutput({tag, "_idle_req"}, 32'(bus_req), 32'd0);
    checkOutput({tag, "_idle_data"}, r_Data_M, 32'h0);
  endtask

  // Store with immediate ready; write stays asserted through DONE.
  task automatic runStore(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] expAddr,
                          input logic [3:0] expBe, input logic [31:0] expWdata);
    applyStimulus(1'b0, 1'b1, f3, addr, data, 1'b0, 1'b0, 32'h0);
    checkOutput({tag, "_launch_stall"}, 32'(stall_M), 32'd1);
    checkOutput({tag, "_launch_req"}, 32'(bus_req), 32'd0);
    applyStimulus(1'b0, 1'b1, f3, addr, data, 1'b1, 1'b0, 32'h0);
    checkOutput({tag, "_req"}, 32'(bus_req), 32'd1);
    checkOutput({tag, "_we"}, 32'(bus_we), 32'd1);
    checkOutput({tag, "_addr"}, bus_addr, expAddr);
    checkOutput({tag, "_be"}, 32'(bus_be), 32'(expBe));
    checkOutput({tag, "_wdata"}, bus_wdata, expWdata);
    checkOutput({tag, "_req_stall"}, 32'(stall_M), 32'd1);
    checkOutput({tag, "_req_exc"}, 32'(exc_M), 32'd0);
    applyStimulus(1'b0, 1'b1, f3, addr, data, 1'b0, 1'b0, 32'h0);
    checkOutput({tag, "_done_stall"}, 32'(stall_M), 32'd0);
    checkOutput({tag, "_done_exc"}, 32'(exc_M), 32'd0);
    checkOutput({tag, "_done_data"}, r_Data_M, 32'h0);
    checkOutput({tag, "_done_req"}, 32'(bus_req), 32'd0);
    idleCycle();
    checkOutput({tag, "_idle_req"}, 32'(bus_req), 32'd0);
    checkOutput({tag, "_idle_stall"}, 32'(stall_M), 32'd0);
  endtask

  // Illegal request: flagged in the same cycle, no bus activity, no stall.
  task automatic runIllegal(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr);
    applyStimulus(rd, wr, f3, addr, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    checkOutput({tag, "_exc"}, 32'(exc_M), 32'd1);
    checkOutput({tag, "_stall"}, 32'(stall_M), 32'd0);
    checkOutput({tag, "_req"}, 32'(bus_req), 32'd0);
    checkOutput({tag, "_data"}, r_Data_M, 32'h0);
    idleCycle();
    checkOutput({tag, "_after_req"}, 32'(bus_req), 32'd0);
    checkOutput({tag, "_after_exc"}, 32'(exc_M), 32'd0);
  endtask

  // Main directed sequence.
  initial begin
    reset       = 1'b1;
    memRead_M   = 1'b0;
    memWrite_M  = 1'b0;
    funct3_M    = 3'b000;
    ALUResult_M = 32'h0;
    writeData_M = 32'h0;
    bus_ready   = 1'b0;
    bus_rvalid  = 1'b0;
    bus_rdata   = 32'h0;

    // Reset state, with requests presented while reset is held.
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_stall", 32'(stall_M), 32'd0);
    checkOutput("rst_exc", 32'(exc_M), 32'd0);
    checkOutput("rst_req", 32'(bus_req), 32'd0);
    checkOutput("rst_addr", bus_addr, 32'h0);
    checkOutput("rst_be", 32'(bus_be), 32'h0);
    checkOutput("rst_we", 32'(bus_we), 32'd0);
    checkOutput("rst_wdata", bus_wdata, 32'h0);
    checkOutput("rst_data", r_Data_M, 32'h0);
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h3001, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_illegal_exc", 32'(exc_M), 32'd0);
    reset = 1'b0;
    idleCycle();
    checkOutput("idle_stall", 32'(stall_M), 32'd0);
    checkOutput("idle_exc", 32'(exc_M), 32'd0);
    checkOutput("idle_req", 32'(bus_req), 32'd0);

    // LB 0x1003 returning 0x80FF_1234: top byte 0x80 sign-extended.
    runLoad("lb_1003", 3'b000, 32'h0000_1003, 32'h0000_1000, 32'h80FF_1234, 32'hFFFF_FF80);
    runLoad("lh_6002", 3'b001, 32'h0000_6002, 32'h0000_6000, 32'h8001_7FFF, 32'hFFFF_8001);
    runLoad("lh_6000", 3'b001, 32'h0000_6000, 32'h0000_6000, 32'h8001_7FFF, 32'h0000_7FFF);
    runLoad("lbu_7001", 3'b100, 32'h0000_7001, 32'h0000_7000, 32'h0000_9A00, 32'h0000_009A);
    runLoad("lhu_7002", 3'b101, 32'h0000_7002, 32'h0000_7000, 32'hC0DE_0000, 32'h0000_C0DE);
    runLoad("lb_7000", 3'b000, 32'h0000_7000, 32'h0000_7000, 32'h0000_0012, 32'h0000_0012);
    runLoad("lw_8000", 3'b010, 32'h0000_8000, 32'h0000_8000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Stores: lane enables and replicated data.
    runStore("sh_2002", 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF);
    runStore("sh_2000", 3'b001, 32'h0000_2000, 32'h1234_5678, 32'h0000_2000, 4'b0011, 32'h5678_5678);
    runStore("sb_5001", 3'b000, 32'h0000_5001, 32'h0000_00AB, 32'h0000_5000, 4'b0010, 32'hABAB_ABAB);
    runStore("sb_5003", 3'b000, 32'h0000_5003, 32'h1111_22CD, 32'h0000_5000, 4'b1000, 32'hCDCD_CDCD);
    runStore("sw_9004", 3'b010, 32'h0000_9004, 32'hCAFE_F00D, 32'h0000_9004, 4'b1111, 32'hCAFE_F00D);

    // Illegal and misaligned requests.
    runIllegal("lw_misalign", 1'b1, 1'b0, 3'b010, 32'h0000_3001);
    runIllegal("rd_and_wr", 1'b1, 1'b1, 3'b010, 32'h0000_3000);
    runIllegal("sh_misalign", 1'b0, 1'b1, 3'b001, 32'h0000_2001);
    runIllegal("store_f3_100", 1'b0, 1'b1, 3'b100, 32'h0000_2000);
    runIllegal("load_f3_011", 1'b1, 1'b0, 3'b011, 32'h0000_2000);

    // LHU 0x4002 with bus_ready held low: 64 cycles of request, then abort.
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h0000_4002, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("to_launch_stall", 32'(stall_M), 32'd1);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 1'b0, 3'b101, 32'h0000_4002, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("to_req", 32'(bus_req), 32'd1);
      checkOutput("to_addr", bus_addr, 32'h0000_4000);
      checkOutput("to_be", 32'(bus_be), 32'h0);
      checkOutput("to_stall", 32'(stall_M), 32'd1);
      checkOutput("to_exc", 32'(exc_M), 32'd0);
    end
    idleCycle();
    checkOutput("to_done_req", 32'(bus_req), 32'd0);
    checkOutput("to_done_exc", 32'(exc_M), 32'd1);
    checkOutput("to_done_data", r_Data_M, 32'h0);
    checkOutput("to_done_stall", 32'(stall_M), 32'd0);
    idleCycle();
    checkOutput("to_idle_exc", 32'(exc_M), 32'd0);
    checkOutput("to_idle_req", 32'(bus_req), 32'd0);

    // Reset while waiting for read data; the late rvalid must be ignored.
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_A000, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_A000, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("rw_req", 32'(bus_req), 32'd1);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_A000, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("rw_wait_stall", 32'(stall_M), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rw_rst_stall", 32'(stall_M), 32'd0);
    checkOutput("rw_rst_exc", 32'(exc_M), 32'd0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5555_5555);
    reset = 1'b0;
    #1;
    checkOutput("rw_after_req", 32'(bus_req), 32'd0);
    checkOutput("rw_after_addr", bus_addr, 32'h0);
    checkOutput("rw_after_stall", 32'(stall_M), 32'd0);
    checkOutput("rw_after_data", r_Data_M, 32'h0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5555_5555);
    checkOutput("rw_late_data", r_Data_M, 32'h0);
    checkOutput("rw_late_stall", 32'(stall_M), 32'd0);
    checkOutput("rw_late_exc", 32'(exc_M), 32'd0);
    idleCycle();

    // Normal operation resumes after the abandoned access.
    runLoad("lw_b000", 3'b010, 32'h0000_B000, 32'h0000_B000, 32'h0123_4567, 32'h0123_4567);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
